// File: rtl/sync_rom_stream_pkg.sv
// Shared types, defaults and ROM content rule for sync_rom_stream.
// Optional feature macro: ROM_PARITY_EN (adds a registered parity output).
package sync_rom_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_BANKS      = 4;
  localparam int MAX_DATA_WIDTH = 64;

  function automatic int bank_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // The top log2(DATA_WIDTH) address bits, rotated by the bank number, choose the lit bit
  function automatic logic [MAX_DATA_WIDTH-1:0] rom_word(
    input int unsigned bank,
    input int unsigned addr,
    input int unsigned addr_width,
    input int unsigned data_width
  );
    int unsigned iw;
    int unsigned top;
    int unsigned idx;
    iw  = $clog2(data_width);
    top = addr >> (addr_width - iw);
    idx = (top + bank) % data_width;
    return {{(MAX_DATA_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/sync_rom_stream_if.sv
// Request/response bundle between the game datapath and sync_rom_stream.
// Optional feature macro: ROM_PARITY_EN (adds the parity signal).
interface sync_rom_stream_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int BANK_W     = 2
) ();

  logic [BANK_W-1:0]     bank;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] address;
  logic                  start;
  logic [ADDR_WIDTH-1:0] limit;
  logic                  next;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  busy;
  logic                  done;
`ifdef ROM_PARITY_EN
  logic                  parity;
`endif

  modport master (
    output bank, rd_en, address, start, limit, next,
    input  data_out, valid, busy, done
`ifdef ROM_PARITY_EN
    , input parity
`endif
  );

  modport slave (
    input  bank, rd_en, address, start, limit, next,
    output data_out, valid, busy, done
`ifdef ROM_PARITY_EN
    , output parity
`endif
  );

endinterface

// File: rtl/sync_rom_stream_rom_content.sv
// Combinational pattern lookup (bank, addr) -> one-hot word; banks past BANKS read as zero.
module rom_content
  import sync_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANKS      = DEF_BANKS,
  parameter int BANK_W     = 2
) (
  input  logic [BANK_W-1:0]     bank,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] word
);

  always_comb begin
    word = DATA_WIDTH'(rom_word(int'(bank), int'(addr), ADDR_WIDTH, DATA_WIDTH));
    if (int'(bank) >= BANKS) begin
      word = '0;
    end
  end

endmodule

// File: rtl/sync_rom_stream.sv
// Banked pattern ROM with one-cycle random reads and a valid/next streaming sequencer.
// Optional feature macro: ROM_PARITY_EN (registered XOR-reduce of each loaded word).
module sync_rom_stream
  import sync_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANKS      = DEF_BANKS
) (
  input  logic            clock,
  input  logic            reset,
  sync_rom_stream_if.slave bus
);

  localparam int BANK_W = bank_width(BANKS);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [ADDR_WIDTH-1:0] ptr_inc;
  logic [ADDR_WIDTH-1:0] limit_q;
  logic [ADDR_WIDTH-1:0] limit_next;
  logic [BANK_W-1:0]     bank_q;
  logic [BANK_W-1:0]     bank_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  valid_q;
  logic                  valid_next;
  logic                  busy_q;
  logic                  busy_next;
  logic                  done_q;
  logic                  done_next;
  logic [BANK_W-1:0]     rom_bank;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  assign ptr_inc = ptr + ADDR_WIDTH'(1);

  // One ROM port is shared: streaming looks ahead to ptr+1, idle serves start or rd_en
  always_comb begin
    rom_bank = bus.bank;
    rom_addr = bus.address;
    if (state == STREAM) begin
      rom_bank = bank_q;
      rom_addr = ptr_inc;
    end else if (bus.start) begin
      rom_addr = '0;
    end
  end

  rom_content #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BANKS     (BANKS),
    .BANK_W    (BANK_W)
  ) u_rom_content (
    .bank(rom_bank),
    .addr(rom_addr),
    .word(rom_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = STREAM;
      STREAM:  if (bus.next && (ptr == limit_q)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // valid/busy/done default low so the rd_en pulse and done pulse clear themselves
  always_comb begin
    ptr_next   = ptr;
    limit_next = limit_q;
    bank_next  = bank_q;
    data_next  = data_q;
    valid_next = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bank_next  = bus.bank;
          limit_next = bus.limit;
          ptr_next   = '0;
          data_next  = rom_data;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end else if (bus.rd_en) begin
          data_next  = rom_data;
          valid_next = 1'b1;
        end
      end
      STREAM: begin
        valid_next = 1'b1;
        busy_next  = 1'b1;
        if (bus.next) begin
          if (ptr == limit_q) begin
            valid_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            ptr_next  = ptr_inc;
            data_next = rom_data;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr     <= '0;
      limit_q <= '0;
      bank_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ptr     <= ptr_next;
      limit_q <= limit_next;
      bank_q  <= bank_next;
      data_q  <= data_next;
      valid_q <= valid_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef ROM_PARITY_EN
  logic parity_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_next;
    end
  end

  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_sync_rom_stream.sv
// Self-checking bench for sync_rom_stream: directed and random reads/streams against a reference model.
// Optional feature macro: ROM_PARITY_EN (parity checked when defined).
module tb_sync_rom_stream;

  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int BANKS = 4;
  localparam int BW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [DW-1:0] model_data;

  sync_rom_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_W(BW)) bus ();

  sync_rom_stream #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BANKS     (BANKS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Each group of DEPTH/DW consecutive addresses lights one bit; the bank rotates that bit upward
  function automatic logic [DW-1:0] model_word(input int b, input int a);
    logic [DW-1:0] w;
    int idx;
    w = '0;
    if (b < BANKS) begin
      idx = ((a / (DEPTH / DW)) + b) % DW;
      w[idx] = 1'b1;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_valid, input logic exp_busy, input logic exp_done);
    check_output({tag, ".data_out"}, 32'(bus.data_out), 32'(model_data));
    check_output({tag, ".valid"}, 32'(bus.valid), 32'(exp_valid));
    check_output({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    check_output({tag, ".done"}, 32'(bus.done), 32'(exp_done));
`ifdef ROM_PARITY_EN
    check_output({tag, ".parity"}, 32'(bus.parity), 32'(^model_data));
`endif
  endtask

  task automatic clear_inputs();
    bus.start   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.next    = 1'b0;
    bus.bank    = '0;
    bus.address = '0;
    bus.limit   = '0;
  endtask

  task automatic read_word(input string tag, input int b, input int a);
    bus.rd_en   = 1'b1;
    bus.start   = 1'b0;
    bus.bank    = BW'(b);
    bus.address = AW'(a);
    tick();
    model_data = model_word(b, a);
    check_all(tag, 1'b1, 1'b0, 1'b0);
  endtask

  // mode 0: next held high, mode 1: next pattern 1,0,1 repeating, mode 2: random next
  task automatic run_stream(input string tag, input int b, input int lim, input int mode);
    int  idx;
    bit  nxt;
    bit  finished;
    bus.start   = 1'b1;
    bus.rd_en   = 1'($urandom);
    bus.bank    = BW'(b);
    bus.limit   = AW'(lim);
    bus.address = AW'($urandom);
    bus.next    = 1'($urandom);
    tick();
    idx        = 0;
    finished   = 1'b0;
    model_data = model_word(b, 0);
    check_all({tag, ".first"}, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 200; c++) begin
      case (mode)
        0:       nxt = 1'b1;
        1:       nxt = ((c % 3) != 1);
        default: nxt = 1'($urandom);
      endcase
      bus.next    = nxt;
      bus.start   = 1'($urandom);
      bus.rd_en   = 1'($urandom);
      bus.bank    = BW'($urandom);
      bus.limit   = AW'($urandom);
      bus.address = AW'($urandom);
      tick();
      if (nxt) begin
        if (idx == lim) begin
          check_all({tag, ".done"}, 1'b0, 1'b0, 1'b1);
          finished = 1'b1;
          break;
        end
        idx++;
        model_data = model_word(b, idx);
      end
      check_all({tag, ".word"}, 1'b1, 1'b1, 1'b0);
    end
    check_output({tag, ".completed"}, 32'(finished), 32'd1);
    clear_inputs();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_data = '0;
    clear_inputs();

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_all("reset_idle", 1'b0, 1'b0, 1'b0);

    // Directed random reads, including back-to-back rd_en and the one-cycle valid pulse
    read_word("read_b0_a5", 0, 5);
    check_output("read_b0_a5.pattern", 32'(bus.data_out), 32'h2);
    bus.rd_en = 1'b0;
    tick();
    check_all("read_pulse_end", 1'b0, 1'b0, 1'b0);
    read_word("read_b2_a13", 2, 13);
    check_output("read_b2_a13.pattern", 32'(bus.data_out), 32'h2);
    read_word("read_b1_a15", 1, 15);
    check_output("read_b1_a15.pattern", 32'(bus.data_out), 32'h1);
    bus.rd_en = 1'b0;
    tick();
    check_all("read_hold", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      bus.rd_en   = 1'($urandom);
      bus.next    = 1'($urandom);
      bus.bank    = BW'($urandom);
      bus.address = AW'($urandom);
      tick();
      if (bus.rd_en) model_data = model_word(int'(bus.bank), int'(bus.address));
      check_all("read_random", bus.rd_en, 1'b0, 1'b0);
    end
    clear_inputs();
    tick();

    // Directed streams; the second starts on the edge right after the first's done
    run_stream("stream_b0_l3", 0, 3, 0);
    run_stream("stream_b1_l5", 1, 5, 1);
    tick();
    check_all("after_stream", 1'b0, 1'b0, 1'b0);
    run_stream("stream_l0", 3, 0, 0);

    for (int i = 0; i < 5; i++) begin
      run_stream("stream_random", int'($urandom_range(0, BANKS - 1)), int'($urandom_range(0, DEPTH - 1)), 2);
    end
    run_stream("stream_full", 2, DEPTH - 1, 0);
    tick();
    check_all("idle_after_streams", 1'b0, 1'b0, 1'b0);

    // Reset while streaming at ptr=2: everything clears, no done pulse follows
    bus.start = 1'b1;
    bus.bank  = BW'(3);
    bus.limit = AW'(9);
    tick();
    bus.start = 1'b0;
    bus.next  = 1'b1;
    tick();
    tick();
    model_data = model_word(3, 2);
    check_all("mid_stream_ptr2", 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    model_data = '0;
    check_all("mid_stream_reset", 1'b0, 1'b0, 1'b0);
    reset     = 1'b0;
    bus.next  = 1'b0;
    tick();
    check_all("post_reset_no_done", 1'b0, 1'b0, 1'b0);

    // Reset wins over start and rd_en on the same edge
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.address = AW'(7);
    tick();
    check_all("reset_over_start", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    clear_inputs();
    tick();
    check_all("final_idle", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
